hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, stall/flush control and a data-memory wait FSM.
// Stall/flush/forward are combinational; FSM, timeout flag and perf counters are registered.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] Rd_E,
  input  logic [1:0] ResultSrc_E,
  input  logic       PCSrc_E,
  input  logic [4:0] Rd_M,
  input  logic       RegWrite_M,
  input  logic [4:0] Rd_W,
  input  logic       RegWrite_W,
  input  logic       dmem_req_M,
  input  logic       dmem_ready_M,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       mem_busy,
  output logic       mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       memwait, lw_stall, branch;
  logic [7:0] wait_cnt;

  assign memwait  = dmem_req_M & ~dmem_ready_M;
  assign lw_stall = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                    ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign branch   = ~memwait & PCSrc_E;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs))      return 2'b10;
    else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs)) return 2'b01;
    else                                                    return 2'b00;
  endfunction

  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (!rst) begin
      ForwardA_E = fwd_sel(Rs1_E);
      ForwardB_E = fwd_sel(Rs2_E);
    end
  end

  // Priority: reset, memory wait (freezes everything, no flush of D/E), branch, load-use.
  always_comb begin
    {StallF, StallD, StallE, StallM} = 4'b0000;
    {FlushD, FlushE, FlushW}         = 3'b000;
    if (rst) begin
      {FlushD, FlushE, FlushW} = 3'b111;
    end else if (memwait) begin
      {StallF, StallD, StallE, StallM} = 4'b1111;
      FlushW = 1'b1;
    end else if (PCSrc_E) begin
      {FlushD, FlushE} = 2'b11;
    end else if (lw_stall) begin
      {StallF, StallD} = 2'b11;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (memwait)      state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready_M) state_nxt = RUN;
      default:                    state_nxt = RUN;
    endcase
  end

  always_comb begin
    mem_busy = (state == MEM_WAIT);
  end

  // Timeout fires on the edge after the counter has saturated; the FSM keeps waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else if (state == RUN) begin
      if (memwait) wait_cnt <= 8'd0;
    end else begin
      if (wait_cnt == 8'd255) mem_timeout <= 1'b1;
      else                    wait_cnt    <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (StallF && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (branch && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: reference model feeds an expectation queue, outputs checked before each edge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0] ResultSrc_E;
  logic PCSrc_E, RegWrite_M, RegWrite_W, dmem_req_M, dmem_ready_M;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic mem_busy, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
    .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
    .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .mem_busy(mem_busy), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] stall;   // F D E M
    logic [2:0] flush;   // D E W
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference state
  logic        m_busy = 1'b0;
  logic        m_to = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_fc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t ref_model();
    exp_t e;
    logic mw, lw;
    e = '0;
    if (rst) begin
      e.flush = 3'b111;
      return e;
    end
    e.fa = ref_fwd(Rs1_E);
    e.fb = ref_fwd(Rs2_E);
    mw = dmem_req_M && !dmem_ready_M;
    lw = (ResultSrc_E == 2'b01) && (Rd_E != 0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
    if (mw)           begin e.stall = 4'b1111; e.flush = 3'b001; end
    else if (PCSrc_E) e.flush = 3'b110;
    else if (lw)      begin e.stall = 4'b1100; e.flush = 3'b010; end
    return e;
  endfunction

  task automatic clear_inputs();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
    ResultSrc_E = 2'b00;
    {PCSrc_E, RegWrite_M, RegWrite_W, dmem_req_M, dmem_ready_M} = '0;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    exp_t e;
    q.push_back(ref_model());
    #2;
    e = q.pop_front();
    check("stall", {StallF, StallD, StallE, StallM}, e.stall);
    check("flush", {FlushD, FlushE, FlushW}, e.flush);
    check("fwdA", ForwardA_E, e.fa);
    check("fwdB", ForwardB_E, e.fb);
    check("busy", mem_busy, m_busy);
    check("timeout", mem_timeout, m_to);
    check("stall_cnt", stall_cnt, m_sc);
    check("flush_cnt", flush_cnt, m_fc);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_to = 0; m_wait = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e.stall[3]) m_sc++;
      if (e.flush[2]) m_fc++;
      if (!m_busy) begin
        if (dmem_req_M && !dmem_ready_M) begin m_busy = 1; m_wait = 0; end
      end else begin
        if (m_wait == 255) m_to = 1; else m_wait++;
        if (dmem_ready_M) m_busy = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sc0, fc0;
    int busy_cycles, rise_at;

    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();

    // load-use
    ResultSrc_E = 2'b01; Rd_E = 5'd5; Rs1_D = 5'd5;
    sc0 = stall_cnt;
    #1;
    check("lu_sigs", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    #0 step();
    check("lu_stall_delta", stall_cnt - sc0, 32'd1);

    // branch plus load-use: branch wins
    PCSrc_E = 1'b1;
    sc0 = stall_cnt; fc0 = flush_cnt;
    #1;
    check("br_sigs", {FlushD, FlushE, StallF, StallD}, 4'b1100);
    step();
    check("br_flush_delta", flush_cnt - fc0, 32'd1);
    check("br_stall_delta", stall_cnt - sc0, 32'd0);
    clear_inputs();

    // forward priority
    RegWrite_M = 1; RegWrite_W = 1; Rd_M = 5'd7; Rd_W = 5'd7; Rs1_E = 5'd7;
    #1; check("fwd_mem", ForwardA_E, 2'b10);
    Rd_M = 5'd0;
    #1; check("fwd_wb", ForwardA_E, 2'b01);
    Rd_W = 5'd0;
    #1; check("fwd_rf", ForwardA_E, 2'b00);
    @(negedge clk);
    clear_inputs();

    // memory wait for 3 cycles with a branch in Execute
    busy_cycles = 0;
    dmem_req_M = 1; PCSrc_E = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_sigs", {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}, 7'b1111100);
      busy_cycles += mem_busy;
      #0 step();
    end
    dmem_ready_M = 1; PCSrc_E = 0;
    #1; busy_cycles += mem_busy;
    step();
    dmem_req_M = 0;
    #1; busy_cycles += mem_busy;
    step();
    check("mw_busy_cycles", busy_cycles, 3);
    check("mw_back_run", mem_busy, 1'b0);

    // timeout: rises at the 257th edge after the stall starts (256 edges spent in MEM_WAIT)
    rise_at = 0;
    dmem_req_M = 1; dmem_ready_M = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (mem_timeout && rise_at == 0) rise_at = i;
    end
    check("to_rise_edge", rise_at, 257);
    dmem_ready_M = 1;
    step();
    dmem_req_M = 0;
    step();
    step();
    check("to_sticky", mem_timeout, 1'b1);

    // async reset mid-wait
    dmem_req_M = 1; dmem_ready_M = 0;
    step();
    step();
    check("ar_pre_busy", mem_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", mem_busy, 1'b0);
    check("ar_timeout", mem_timeout, 1'b0);
    check("ar_cnts", stall_cnt | flush_cnt, 32'd0);
    check("ar_flush", {FlushD, FlushE, FlushW, StallF}, 4'b1110);
    m_busy = 0; m_to = 0; m_wait = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    step();
    clear_inputs();
    rst = 1'b0;
    step();
    step();

    // random traffic against the reference model
    for (int i = 0; i < 250; i++) begin
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      Rd_E  = 5'($urandom_range(0, 3)); Rd_M  = 5'($urandom_range(0, 3));
      Rd_W  = 5'($urandom_range(0, 3));
      ResultSrc_E = 2'($urandom_range(0, 3));
      PCSrc_E     = ($urandom_range(0, 3) == 0);
      RegWrite_M  = 1'($urandom);
      RegWrite_W  = 1'($urandom);
      dmem_req_M  = ($urandom_range(0, 3) == 0);
      dmem_ready_M = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
